// File: rtl/regfile_decoded.sv
// rtl/regfile_decoded.sv - decoded-write register file, 1W/2R, with bypass and dirty bitmap
// Optional macro REGFILE_ZERO_REG_EN: register DEPTH-1 reads as zero and ignores writes.
module regfile_decoded #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        rd_addr_a,
  output logic [DATA_W-1:0]        rd_data_a,
  input  logic [ADDR_W-1:0]        rd_addr_b,
  output logic [DATA_W-1:0]        rd_data_b,
  output logic [(1<<ADDR_W)-1:0]   wr_dec,
  input  logic                     clr_dirty,
  output logic [(1<<ADDR_W)-1:0]   dirty
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] TOP_ADDR = {ADDR_W{1'b1}};

  // Registers allowed to accept writes; the top one is masked when it is hardwired to zero.
`ifdef REGFILE_ZERO_REG_EN
  localparam logic [DEPTH-1:0] STORE_MASK = {1'b0, {(DEPTH-1){1'b1}}};
`else
  localparam logic [DEPTH-1:0] STORE_MASK = {DEPTH{1'b1}};
`endif

  logic [DATA_W-1:0] regs [DEPTH];

  // Enabled N-to-2^N write-address decoder; the decoder output is never masked.
  always_comb begin
    wr_dec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_dec[i] = wr_en && (wr_addr == ADDR_W'(i));
    end
  end

  // Storage: async clear, otherwise each decoded enable loads its register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_dec[i] && STORE_MASK[i]) begin
          regs[i] <= wr_data;
        end
      end
    end
  end

  // Dirty bitmap: the clear applies first, so a write in the clear cycle survives it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dirty <= '0;
    end else begin
      dirty <= ((clr_dirty ? '0 : dirty) | wr_dec) & STORE_MASK;
    end
  end

  // Read port A: stored value, overridden by same-cycle write data when bypassing.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if ((BYPASS != 0) && wr_en && (rd_addr_a == wr_addr)) begin
      rd_data_a = wr_data;
    end
`ifdef REGFILE_ZERO_REG_EN
    if (rd_addr_a == TOP_ADDR) begin
      rd_data_a = '0;
    end
`endif
  end

  // Read port B: same rules as port A, fully independent.
  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if ((BYPASS != 0) && wr_en && (rd_addr_b == wr_addr)) begin
      rd_data_b = wr_data;
    end
`ifdef REGFILE_ZERO_REG_EN
    if (rd_addr_b == TOP_ADDR) begin
      rd_data_b = '0;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_decoded.sv
// tb/tb_regfile_decoded.sv - scoreboard bench for regfile_decoded, bypass and non-bypass instances
module tb_regfile_decoded;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_TOP = 1'b1;
`else
  localparam bit ZERO_TOP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        clr_dirty;
  logic [63:0] rd_data_a, rd_data_b, rd_data_a_nb, rd_data_b_nb;
  logic [31:0] wr_dec, dirty, wr_dec_nb, dirty_nb;

  regfile_decoded #(.ADDR_W(5), .DATA_W(64), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .wr_dec(wr_dec), .clr_dirty(clr_dirty), .dirty(dirty)
  );

  regfile_decoded #(.ADDR_W(5), .DATA_W(64), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a_nb), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b_nb),
    .wr_dec(wr_dec_nb), .clr_dirty(clr_dirty), .dirty(dirty_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a, b, na, nb;
    logic [31:0] dec, dirty;
  } exp_t;

  exp_t exp_q[$];
  int compared = 0;
  int mismatched = 0;

  // reference model: plain array of register contents plus a set of written indices
  logic [63:0] mreg [32];
  bit          mdirty [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] model_read(input logic [4:0] addr, input bit byp);
    if (ZERO_TOP && addr == 5'd31) return 64'h0;
    if (byp && wr_en && addr == wr_addr) return wr_data;
    return mreg[addr];
  endfunction

  function automatic logic [31:0] model_dirty();
    logic [31:0] d = '0;
    for (int i = 0; i < 32; i++) d[i] = mdirty[i];
    return d;
  endfunction

  function automatic exp_t model_now();
    exp_t e;
    e.a     = model_read(rd_addr_a, 1'b1);
    e.b     = model_read(rd_addr_b, 1'b1);
    e.na    = model_read(rd_addr_a, 1'b0);
    e.nb    = model_read(rd_addr_b, 1'b0);
    e.dec   = wr_en ? (32'h1 << wr_addr) : 32'h0;
    e.dirty = reset ? 32'h0 : model_dirty();
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mreg[i]   = 64'h0;
      mdirty[i] = 1'b0;
    end
  endtask

  // drive one cycle of inputs, record expected outputs, then advance the model past the edge
  task automatic cyc(input logic en, input logic [4:0] wa, input logic [63:0] wd,
                     input logic [4:0] ra, input logic [4:0] rb, input logic clr);
    @(posedge clk);
    #1;
    wr_en = en; wr_addr = wa; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb; clr_dirty = clr;
    exp_q.push_back(model_now());
    if (!reset) begin
      if (clr) for (int i = 0; i < 32; i++) mdirty[i] = 1'b0;
      if (en && !(ZERO_TOP && wa == 5'd31)) begin
        mreg[wa]   = wd;
        mdirty[wa] = 1'b1;
      end
    end
  endtask

  // monitor: outputs are combinational/registered, so each cycle presents one result at negedge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rd_data_a",    rd_data_a,    e.a);
      chk("rd_data_b",    rd_data_b,    e.b);
      chk("rd_data_a_nb", rd_data_a_nb, e.na);
      chk("rd_data_b_nb", rd_data_b_nb, e.nb);
      chk("wr_dec",       {32'h0, wr_dec},    {32'h0, e.dec});
      chk("wr_dec_nb",    {32'h0, wr_dec_nb}, {32'h0, e.dec});
      chk("dirty",        {32'h0, dirty},     {32'h0, e.dirty});
      chk("dirty_nb",     {32'h0, dirty_nb},  {32'h0, e.dirty});
    end
  end

  initial begin
    reset = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; clr_dirty = 1'b0;
    model_clear();
    #2 reset = 1'b1;

    // reset state, observed while reset is still high
    cyc(1'b0, 5'd0, 64'h0, 5'd3, 5'd31, 1'b0);
    @(negedge clk);
    #1 reset = 1'b0;

    // decode and first write
    cyc(1'b1, 5'd3, 64'hA5, 5'd3, 5'd4, 1'b0);
    cyc(1'b0, 5'd0, 64'h0, 5'd3, 5'd3, 1'b0);

    // bypass on both ports at once
    cyc(1'b1, 5'd7, 64'h1234, 5'd7, 5'd7, 1'b0);
    cyc(1'b0, 5'd7, 64'h0, 5'd7, 5'd7, 1'b0);

    // sweep writes, then read-only sweep with decoder idle
    for (int i = 0; i < 32; i++)
      cyc(1'b1, 5'(i), 64'(i * 'h11), 5'(i), 5'($urandom_range(0, 31)), 1'b0);
    for (int i = 0; i < 32; i++)
      cyc(1'b0, 5'(i), 64'h0, 5'(i), 5'(31 - i), 1'b0);

    // clear coinciding with a write, and back-to-back writes to one address
    cyc(1'b1, 5'd2, 64'h22, 5'd2, 5'd0, 1'b1);
    cyc(1'b1, 5'd9, 64'h1111, 5'd9, 5'd2, 1'b0);
    cyc(1'b1, 5'd9, 64'h2222, 5'd9, 5'd9, 1'b0);
    cyc(1'b0, 5'd0, 64'h0, 5'd9, 5'd2, 1'b0);

    // top register (hardwired zero when the option is built in)
    cyc(1'b1, 5'd31, 64'hDEAD, 5'd31, 5'd31, 1'b0);
    cyc(1'b0, 5'd0, 64'h0, 5'd31, 5'd31, 1'b0);
    cyc(1'b1, 5'd0, 64'hBEEF, 5'd0, 5'd31, 1'b0);

    // randomized traffic
    for (int n = 0; n < 400; n++)
      cyc(1'($urandom_range(0, 3) != 0), 5'($urandom), {$urandom, $urandom},
          5'($urandom), 5'($urandom), 1'($urandom_range(0, 15) == 0));

    // async reset pulse between edges: outputs must clear before the next edge
    cyc(1'b0, 5'd0, 64'h0, 5'd9, 5'd0, 1'b0);
    @(posedge clk);
    #2;
    rd_addr_a = 5'd5; rd_addr_b = 5'd9;
    reset = 1'b1;
    model_clear();
    exp_q.push_back(model_now());
    #6 reset = 1'b0;
    cyc(1'b0, 5'd0, 64'h0, 5'd5, 5'd9, 1'b0);

    for (int n = 0; n < 100; n++)
      cyc(1'($urandom_range(0, 1)), 5'($urandom), {$urandom, $urandom},
          5'($urandom), 5'($urandom), 1'($urandom_range(0, 15) == 0));

    // let the monitor drain, bounded
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
